// File: rtl/mem_stage_ctrl_pkg.sv
// Shared LC-3b type definitions used by the MEM stage and its data formatter.
package lc3b_types;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } mem_state_t;

  typedef logic [1:0] lc3b_mem_be;

  localparam lc3b_mem_be BE_WORD = 2'b11;
  localparam lc3b_mem_be BE_LO   = 2'b01;
  localparam lc3b_mem_be BE_HI   = 2'b10;

  function automatic logic [15:0] sext8(input logic [7:0] b);
    return {{8{b[7]}}, b};
  endfunction

endpackage

// File: rtl/mem_stage_ctrl_data_format.sv
// Combinational byte/word lane formatting for LC-3b data-cache accesses:
// request-side address/enable/store-data shaping and response-side load extraction.
module mem_data_format
  import lc3b_types::*;
(
  input  logic             byte_op_i,
  input  logic [15:0]      addr_i,
  input  logic [15:0]      wdata_i,
  input  logic             rsp_byte_op_i,
  input  logic             rsp_lane_i,
  input  logic [15:0]      rsp_rdata_i,
  output logic [15:0]      address_o,
  output lc3b_mem_be       byte_enable_o,
  output logic [15:0]      wdata_o,
  output logic [15:0]      rdata_o
);

  always_comb begin
    if (byte_op_i) begin
      address_o     = addr_i;
      byte_enable_o = addr_i[0] ? BE_HI : BE_LO;
      wdata_o       = {wdata_i[7:0], wdata_i[7:0]};
    end else begin
      address_o     = {addr_i[15:1], 1'b0};
      byte_enable_o = BE_WORD;
      wdata_o       = wdata_i;
    end
  end

  // Lane 1 is the odd (high) byte of the word.
  always_comb begin
    if (rsp_byte_op_i) begin
      rdata_o = rsp_lane_i ? sext8(rsp_rdata_i[15:8]) : sext8(rsp_rdata_i[7:0]);
    end else begin
      rdata_o = rsp_rdata_i;
    end
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// LC-3b MEM stage data-cache controller: request/response handshake, stall, load return.
// Optional watchdog on mem_resp is built when MEM_TIMEOUT_EN is defined.
module mem_stage_ctrl
  import lc3b_types::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic        read_memory,
  input  logic        write_memory,
  input  logic        byte_op,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  input  logic        mem_resp,
  input  logic [15:0] mem_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [15:0] mem_address,
  output logic [15:0] mem_wdata,
  output logic [1:0]  mem_byte_enable,
  output logic        stall,
  output logic [15:0] rdata_out,
  output logic        rdata_valid,
  output logic        timeout_err
);

  mem_state_t  state_q;
  logic        mem_read_q;
  logic        mem_write_q;
  logic [15:0] mem_address_q;
  logic [15:0] mem_wdata_q;
  lc3b_mem_be  mem_be_q;
  logic        byte_op_q;
  logic [15:0] rdata_out_q;
  logic        rdata_valid_q;

  logic        req;
  logic [15:0] fmt_address;
  lc3b_mem_be  fmt_be;
  logic [15:0] fmt_wdata;
  logic [15:0] fmt_rdata;

  assign req = valid_in & (read_memory | write_memory);

  mem_data_format u_fmt (
    .byte_op_i     (byte_op),
    .addr_i        (addr),
    .wdata_i       (wdata),
    .rsp_byte_op_i (byte_op_q),
    .rsp_lane_i    (mem_address_q[0]),
    .rsp_rdata_i   (mem_rdata),
    .address_o     (fmt_address),
    .byte_enable_o (fmt_be),
    .wdata_o       (fmt_wdata),
    .rdata_o       (fmt_rdata)
  );

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wait_cnt_q;
  logic             timeout_err_q;

  assign timeout_err = timeout_err_q;
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout_err        = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= 16'h0000;
      mem_wdata_q   <= 16'h0000;
      mem_be_q      <= 2'b00;
      byte_op_q     <= 1'b0;
      rdata_out_q   <= 16'h0000;
      rdata_valid_q <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      wait_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          rdata_valid_q <= 1'b0;
`ifdef MEM_TIMEOUT_EN
          wait_cnt_q    <= '0;
`endif
          // A simultaneous load/store request resolves to the store.
          if (req) begin
            mem_address_q <= fmt_address;
            mem_wdata_q   <= fmt_wdata;
            mem_be_q      <= fmt_be;
            byte_op_q     <= byte_op;
            if (write_memory) begin
              state_q     <= WRITE;
              mem_write_q <= 1'b1;
            end else begin
              state_q     <= READ;
              mem_read_q  <= 1'b1;
            end
          end
        end
        READ, WRITE: begin
          if (mem_resp) begin
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            state_q     <= DONE;
            if (state_q == READ) begin
              rdata_out_q   <= fmt_rdata;
              rdata_valid_q <= 1'b1;
            end
          end
`ifdef MEM_TIMEOUT_EN
          else if (wait_cnt_q == TIMEOUT_LAST) begin
            timeout_err_q <= 1'b1;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            state_q       <= DONE;
            if (state_q == READ) begin
              rdata_out_q   <= 16'h0000;
              rdata_valid_q <= 1'b1;
            end
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
`endif
        end
        DONE: begin
          rdata_valid_q <= 1'b0;
          state_q       <= IDLE;
`ifdef MEM_TIMEOUT_EN
          wait_cnt_q    <= '0;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Stall is withheld while reset is asserted so an abandoned access frees the pipe at once.
  always_comb begin
    stall = 1'b0;
    if (!reset) begin
      unique case (state_q)
        IDLE:        stall = req;
        READ, WRITE: stall = 1'b1;
        DONE:        stall = 1'b0;
        default:     stall = 1'b0;
      endcase
    end
  end

  assign mem_read        = mem_read_q;
  assign mem_write       = mem_write_q;
  assign mem_address     = mem_address_q;
  assign mem_wdata       = mem_wdata_q;
  assign mem_byte_enable = mem_be_q;
  assign rdata_out       = rdata_out_q;
  assign rdata_valid     = rdata_valid_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed self-checking bench for mem_stage_ctrl (timeout steps build with MEM_TIMEOUT_EN).
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic        read_memory;
  logic        write_memory;
  logic        byte_op;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        mem_resp;
  logic [15:0] mem_rdata;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_address;
  logic [15:0] mem_wdata;
  logic [1:0]  mem_byte_enable;
  logic        stall;
  logic [15:0] rdata_out;
  logic        rdata_valid;
  logic        timeout_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_stage_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .valid_in        (valid_in),
    .read_memory     (read_memory),
    .write_memory    (write_memory),
    .byte_op         (byte_op),
    .addr            (addr),
    .wdata           (wdata),
    .mem_resp        (mem_resp),
    .mem_rdata       (mem_rdata),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata),
    .mem_byte_enable (mem_byte_enable),
    .stall           (stall),
    .rdata_out       (rdata_out),
    .rdata_valid     (rdata_valid),
    .timeout_err     (timeout_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic rd, input logic wr, input logic bo,
                               input logic [15:0] a, input logic [15:0] wd);
    valid_in     = v;
    read_memory  = rd;
    write_memory = wr;
    byte_op      = bo;
    addr         = a;
    wdata        = wd;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    reset     = 1'b1;
    mem_resp  = 1'b0;
    mem_rdata = 16'h0000;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    tick();
    tick();
    checkOutput("rst_mem_read",    16'(mem_read), 16'h0);
    checkOutput("rst_mem_write",   16'(mem_write), 16'h0);
    checkOutput("rst_address",     mem_address, 16'h0000);
    checkOutput("rst_wdata",       mem_wdata, 16'h0000);
    checkOutput("rst_be",          16'(mem_byte_enable), 16'h0);
    checkOutput("rst_stall",       16'(stall), 16'h0);
    checkOutput("rst_rdata",       rdata_out, 16'h0000);
    checkOutput("rst_rdata_valid", 16'(rdata_valid), 16'h0);
    checkOutput("rst_timeout",     16'(timeout_err), 16'h0);
    reset = 1'b0;
    tick();

    // mem_resp while idle must be ignored
    mem_resp  = 1'b1;
    mem_rdata = 16'hFFFF;
    #1;
    checkOutput("idle_resp_stall", 16'(stall), 16'h0);
    tick();
    checkOutput("idle_resp_read",  16'(mem_read), 16'h0);
    checkOutput("idle_resp_valid", 16'(rdata_valid), 16'h0);
    checkOutput("idle_resp_rdata", rdata_out, 16'h0000);
    mem_resp = 1'b0;

    // Word load at odd address, response on 2nd cycle after mem_read rises
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 16'h1235, 16'h0000);
    #1;
    checkOutput("wl_stall_idle", 16'(stall), 16'h1);
    tick();
    checkOutput("wl_mem_read",   16'(mem_read), 16'h1);
    checkOutput("wl_mem_write",  16'(mem_write), 16'h0);
    checkOutput("wl_address",    mem_address, 16'h1234);
    checkOutput("wl_be",         16'(mem_byte_enable), 16'h3);
    checkOutput("wl_stall_wait", 16'(stall), 16'h1);
    tick();
    checkOutput("wl_read_held",  16'(mem_read), 16'h1);
    checkOutput("wl_valid_wait", 16'(rdata_valid), 16'h0);
    mem_resp  = 1'b1;
    mem_rdata = 16'hBEEF;
    tick();
    checkOutput("wl_read_drop",  16'(mem_read), 16'h0);
    checkOutput("wl_rdata",      rdata_out, 16'hBEEF);
    checkOutput("wl_valid_done", 16'(rdata_valid), 16'h1);
    checkOutput("wl_stall_done", 16'(stall), 16'h0);
    mem_resp = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    tick();
    checkOutput("wl_valid_once", 16'(rdata_valid), 16'h0);
    checkOutput("wl_idle_read",  16'(mem_read), 16'h0);

    // Byte store to odd byte
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 16'h2001, 16'h00A5);
    tick();
    checkOutput("bs_mem_write", 16'(mem_write), 16'h1);
    checkOutput("bs_mem_read",  16'(mem_read), 16'h0);
    checkOutput("bs_wdata",     mem_wdata, 16'hA5A5);
    checkOutput("bs_be",        16'(mem_byte_enable), 16'h2);
    checkOutput("bs_address",   mem_address, 16'h2001);
    tick();
    tick();
    checkOutput("bs_write_held", 16'(mem_write), 16'h1);
    checkOutput("bs_stall_held", 16'(stall), 16'h1);
    mem_resp = 1'b1;
    tick();
    checkOutput("bs_write_drop", 16'(mem_write), 16'h0);
    checkOutput("bs_valid_done", 16'(rdata_valid), 16'h0);
    checkOutput("bs_stall_done", 16'(stall), 16'h0);
    mem_resp = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    tick();

    // Byte load, low lane: 0x80 sign-extends
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 16'h3000, 16'h0000);
    tick();
    checkOutput("bl0_be",      16'(mem_byte_enable), 16'h1);
    checkOutput("bl0_address", mem_address, 16'h3000);
    mem_resp  = 1'b1;
    mem_rdata = 16'h7F80;
    tick();
    checkOutput("bl0_rdata", rdata_out, 16'hFF80);
    checkOutput("bl0_valid", 16'(rdata_valid), 16'h1);
    mem_resp = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    tick();

    // Byte load, high lane: 0x7F stays positive
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 16'h3001, 16'h0000);
    tick();
    checkOutput("bl1_be", 16'(mem_byte_enable), 16'h2);
    mem_resp  = 1'b1;
    mem_rdata = 16'h7F80;
    tick();
    checkOutput("bl1_rdata", rdata_out, 16'h007F);
    mem_resp = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    tick();

    // Read and write together: store wins
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 16'h4003, 16'h1234);
    tick();
    checkOutput("cf_mem_write", 16'(mem_write), 16'h1);
    checkOutput("cf_mem_read",  16'(mem_read), 16'h0);
    checkOutput("cf_address",   mem_address, 16'h4002);
    checkOutput("cf_wdata",     mem_wdata, 16'h1234);
    mem_resp = 1'b1;
    tick();
    checkOutput("cf_valid_done", 16'(rdata_valid), 16'h0);
    mem_resp = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    tick();

    // Reset between edges during a read
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 16'h5000, 16'h0000);
    tick();
    checkOutput("rm_read_before", 16'(mem_read), 16'h1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("rm_read_drop",  16'(mem_read), 16'h0);
    checkOutput("rm_stall_drop", 16'(stall), 16'h0);
    checkOutput("rm_valid_drop", 16'(rdata_valid), 16'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    tick();
    reset = 1'b0;
    tick();
    checkOutput("rm_idle_stall", 16'(stall), 16'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 16'h6000, 16'h0000);
    tick();
    checkOutput("rm_new_read", 16'(mem_read), 16'h1);
    checkOutput("rm_new_addr", mem_address, 16'h6000);
    mem_resp  = 1'b1;
    mem_rdata = 16'h1111;
    tick();
    checkOutput("rm_new_rdata", rdata_out, 16'h1111);
    mem_resp = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    tick();

`ifdef MEM_TIMEOUT_EN
    // Read with no response: watchdog fires after 4 wait cycles
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 16'h7000, 16'h0000);
    tick();
    tick();
    tick();
    tick();
    checkOutput("to_read_held", 16'(mem_read), 16'h1);
    checkOutput("to_err_early", 16'(timeout_err), 16'h0);
    tick();
    checkOutput("to_err",       16'(timeout_err), 16'h1);
    checkOutput("to_stall",     16'(stall), 16'h0);
    checkOutput("to_read_drop", 16'(mem_read), 16'h0);
    checkOutput("to_rdata",     rdata_out, 16'h0000);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    tick();
    checkOutput("to_sticky",    16'(timeout_err), 16'h1);
`else
    checkOutput("no_timeout", 16'(timeout_err), 16'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
